// File: rtl/dmem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_pkg
// Brief    : Shared pipeline types and constants for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_access_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_REG_W  = 5;

    localparam logic [c_DATA_W-1:0] c_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_timer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_timer
// Brief    : Access-wait counter; flags expiry at TIMEOUT-1 counted cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                  c_CNT_W = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_access.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access
// Brief    : Memory-stage req/ack data-memory controller with stall,
//            load capture and timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int                  TIMEOUT  = 16,
    parameter logic [c_DATA_W-1:0] ERR_DATA = c_ERR_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                sel_wb_in,
    input  logic                reg_rw_in,
    input  logic [c_REG_W-1:0]  addr_dst_in,
    input  logic [c_DATA_W-1:0] alu_result_in,
    input  logic [c_DATA_W-1:0] store_data_in,
    output logic                dm_req,
    output logic                dm_we,
    output logic [c_DATA_W-1:0] dm_addr,
    output logic [c_DATA_W-1:0] dm_wdata,
    input  logic [c_DATA_W-1:0] dm_rdata,
    input  logic                dm_ack,
    output logic                stall,
    output logic                sel_wb_out,
    output logic                reg_rw_out,
    output logic [c_REG_W-1:0]  addr_dst_out,
    output logic [c_DATA_W-1:0] alu_result_out,
    output logic [c_DATA_W-1:0] data_out_out,
    output logic                bus_err
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_acc;
    logic                w_stall;
    logic                w_latch;
    logic                w_capture;
    logic                w_abort;
    logic                w_expired;
    logic                r_dm_req;
    logic                r_dm_we;
    logic [c_DATA_W-1:0] r_dm_addr;
    logic [c_DATA_W-1:0] r_dm_wdata;
    logic [c_DATA_W-1:0] r_rdata;
    logic                r_bus_err;

    assign w_acc = mem_read_in | mem_write_in;

    dmem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_latch),
        .en      (r_state == BUSY),
        .expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                // A late ack in the expiry cycle still completes normally
                if (dm_ack) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_dm_req   <= 1'b1;
                r_dm_addr  <= alu_result_in;
                r_dm_wdata <= store_data_in;
                r_dm_we    <= mem_write_in;
            end
            if (w_capture || w_abort) begin
                r_dm_req <= 1'b0;
            end
            if (w_capture && !r_dm_we) begin
                r_rdata <= dm_rdata;
            end
            if (w_abort) begin
                r_bus_err <= 1'b1;
                if (!r_dm_we) begin
                    r_rdata <= ERR_DATA;
                end
            end
        end
    end

    // Write-back bundle becomes a bubble only through reg_rw while stalled
    assign stall          = w_stall;
    assign reg_rw_out     = reg_rw_in & ~w_stall;
    assign sel_wb_out     = sel_wb_in;
    assign addr_dst_out   = addr_dst_in;
    assign alu_result_out = alu_result_in;
    assign data_out_out   = r_rdata;
    assign dm_req         = r_dm_req;
    assign dm_we          = r_dm_we;
    assign dm_addr        = r_dm_addr;
    assign dm_wdata       = r_dm_wdata;
    assign bus_err        = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access
// Brief    : Directed self-checking bench for dmem_access (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        sel_wb_in = 1'b0;
    logic        reg_rw_in = 1'b0;
    logic [4:0]  addr_dst_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] store_data_in = '0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        stall;
    logic        sel_wb_out;
    logic        reg_rw_out;
    logic [4:0]  addr_dst_out;
    logic [31:0] alu_result_out;
    logic [31:0] data_out_out;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    int          a_stall;
    logic        a_unstable;
    logic        a_rw_leak;
    logic        a_req_bad;
    logic        a_idle_req;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we;

    dmem_access #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .sel_wb_in      (sel_wb_in),
        .reg_rw_in      (reg_rw_in),
        .addr_dst_in    (addr_dst_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_ack         (dm_ack),
        .stall          (stall),
        .sel_wb_out     (sel_wb_out),
        .reg_rw_out     (reg_rw_out),
        .addr_dst_out   (addr_dst_out),
        .alu_result_out (alu_result_out),
        .data_out_out   (data_out_out),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    // Stimulus only: presents one access the cycle after the next edge, acks
    // in BUSY cycle number wt, returns in the DONE cycle with observations.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int wt);
        @(posedge clk); #1;
        mem_read_in   = rd;
        mem_write_in  = wr;
        alu_result_in = addr;
        store_data_in = wdata;
        reg_rw_in     = 1'b1;
        sel_wb_in     = rd;
        addr_dst_in   = 5'd9;
        #1;
        a_stall    = stall ? 1 : 0;
        a_rw_leak  = stall & reg_rw_out;
        a_idle_req = dm_req;
        a_unstable = 1'b0;
        a_req_bad  = 1'b0;
        a_addr     = '0;
        a_wdata    = '0;
        a_we       = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            dm_ack   = (c == wt);
            dm_rdata = rdata;
            #1;
            if (!stall) break;
            a_stall++;
            if (c == 0) begin
                a_addr  = dm_addr;
                a_wdata = dm_wdata;
                a_we    = dm_we;
            end else if (dm_addr !== a_addr || dm_wdata !== a_wdata || dm_we !== a_we) begin
                a_unstable = 1'b1;
            end
            if (dm_req !== 1'b1) a_req_bad = 1'b1;
            if (reg_rw_out !== 1'b0) a_rw_leak = 1'b1;
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_reset();
        reg_rw_in     = 1'b1;
        sel_wb_in     = 1'b1;
        addr_dst_in   = 5'd7;
        alu_result_in = 32'h55;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
        checks++; if (reg_rw_out !== 1'b1) begin errors++; $display("FAIL rst_reg_rw got %0b want 1", reg_rw_out); end
        checks++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin errors++; $display("FAIL rst_req_we got %0b%0b want 00", dm_req, dm_we); end
        checks++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_wdata got %h %h want 0 0", dm_addr, dm_wdata); end
        checks++; if (data_out_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", data_out_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %0b want 0", bus_err); end
        checks++; if (addr_dst_out !== 5'd7 || alu_result_out !== 32'h55 || sel_wb_out !== 1'b1) begin
            errors++; $display("FAIL rst_passthru got %0d %h %0b want 7 55 1", addr_dst_out, alu_result_out, sel_wb_out); end
        mem_read_in = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || reg_rw_out !== 1'b0) begin
            errors++; $display("FAIL rst_acc_detect got stall=%0b rw=%0b want 1 0", stall, reg_rw_out); end
        mem_read_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load();
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);
        checks++; if (a_stall != 2) begin errors++; $display("FAIL load_stall_cycles got %0d want 2", a_stall); end
        checks++; if (a_addr !== 32'h100 || a_we !== 1'b0) begin errors++; $display("FAIL load_addr_we got %h %0b want 100 0", a_addr, a_we); end
        checks++; if (a_req_bad || a_idle_req || a_rw_leak) begin
            errors++; $display("FAIL load_req_rw got bad=%0b idle=%0b leak=%0b want 0 0 0", a_req_bad, a_idle_req, a_rw_leak); end
        checks++; if (data_out_out !== 32'h1234_5678) begin errors++; $display("FAIL load_data got %h want 12345678", data_out_out); end
        checks++; if (reg_rw_out !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0) begin
            errors++; $display("FAIL load_done got rw=%0b stall=%0b req=%0b want 1 0 0", reg_rw_out, stall, dm_req); end
        checks++; if (alu_result_out !== 32'h100 || addr_dst_out !== 5'd9) begin
            errors++; $display("FAIL load_wb got %h %0d want 100 9", alu_result_out, addr_dst_out); end
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 32'h200, 32'hCAFE_0001, 32'hBAD0_0000, 3);
        checks++; if (a_stall != 5) begin errors++; $display("FAIL store_stall_cycles got %0d want 5", a_stall); end
        checks++; if (a_we !== 1'b1 || a_wdata !== 32'hCAFE_0001 || a_addr !== 32'h200) begin
            errors++; $display("FAIL store_bus got we=%0b %h %h want 1 cafe0001 200", a_we, a_wdata, a_addr); end
        checks++; if (a_unstable || a_req_bad) begin errors++; $display("FAIL store_stable got unst=%0b reqbad=%0b want 0 0", a_unstable, a_req_bad); end
        checks++; if (data_out_out !== 32'h1234_5678) begin errors++; $display("FAIL store_rdata_kept got %h want 12345678", data_out_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL store_bus_err got %0b want 0", bus_err); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h7777_7777, 1000);
        checks++; if (a_stall != 5) begin errors++; $display("FAIL to_stall_cycles got %0d want 5", a_stall); end
        checks++; if (data_out_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data got %h want deadbeef", data_out_out); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err got %0b want 1", bus_err); end
        run_access(1'b1, 1'b0, 32'h304, 32'h0, 32'h0000_1111, 0);
        checks++; if (data_out_out !== 32'h0000_1111) begin errors++; $display("FAIL to_recover_data got %h want 00001111", data_out_out); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", bus_err); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_rw_in = 1'b1; alu_result_in = 32'h42;
        #1;
        checks++; if (stall !== 1'b0 || reg_rw_out !== 1'b1 || alu_result_out !== 32'h42) begin
            errors++; $display("FAIL b2b_alu1 got stall=%0b rw=%0b %h want 0 1 42", stall, reg_rw_out, alu_result_out); end
        run_access(1'b1, 1'b0, 32'h400, 32'h0, 32'hAAAA_0001, 0);
        checks++; if (a_stall != 2 || data_out_out !== 32'hAAAA_0001) begin
            errors++; $display("FAIL b2b_load1 got stall=%0d %h want 2 aaaa0001", a_stall, data_out_out); end
        run_access(1'b1, 1'b0, 32'h404, 32'h0, 32'hAAAA_0002, 1);
        checks++; if (a_stall != 3 || a_idle_req || a_rw_leak || a_addr !== 32'h404) begin
            errors++; $display("FAIL b2b_load2 got stall=%0d idle=%0b leak=%0b %h want 3 0 0 404", a_stall, a_idle_req, a_rw_leak, a_addr); end
        checks++; if (data_out_out !== 32'hAAAA_0002) begin errors++; $display("FAIL b2b_load2_data got %h want aaaa0002", data_out_out); end
        @(posedge clk); #1;
        mem_read_in = 1'b0; alu_result_in = 32'h43;
        #1;
        checks++; if (stall !== 1'b0 || reg_rw_out !== 1'b1 || alu_result_out !== 32'h43) begin
            errors++; $display("FAIL b2b_alu2 got stall=%0b rw=%0b %h want 0 1 43", stall, reg_rw_out, alu_result_out); end
    endtask

    task automatic test_both_high();
        run_access(1'b1, 1'b1, 32'h500, 32'h5555_0000, 32'hBBBB_BBBB, 0);
        checks++; if (a_we !== 1'b1 || a_wdata !== 32'h5555_0000) begin
            errors++; $display("FAIL both_we got we=%0b %h want 1 55550000", a_we, a_wdata); end
        checks++; if (data_out_out !== 32'hAAAA_0002) begin errors++; $display("FAIL both_rdata_kept got %h want aaaa0002", data_out_out); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_read_in = 1'b1; mem_write_in = 1'b0; alu_result_in = 32'h600; reg_rw_in = 1'b1;
        @(posedge clk); #1;
        checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL mid_busy_req got %0b want 1", dm_req); end
        rst = 1'b1;
        #1;
        checks++; if (dm_req !== 1'b0 || dm_addr !== 32'h0 || data_out_out !== 32'h0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_clear got req=%0b %h %h err=%0b want 0 0 0 0", dm_req, dm_addr, data_out_out, bus_err); end
        checks++; if (stall !== 1'b1 || reg_rw_out !== 1'b0) begin
            errors++; $display("FAIL mid_rst_detect got stall=%0b rw=%0b want 1 0", stall, reg_rw_out); end
        mem_read_in = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || reg_rw_out !== 1'b1) begin
            errors++; $display("FAIL mid_rst_idle got stall=%0b rw=%0b want 0 1", stall, reg_rw_out); end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
            #1;
            checks++; if (dm_req !== 1'b0 || stall !== 1'b0 || data_out_out !== 32'h0) begin
                errors++; $display("FAIL spurious_ack got req=%0b stall=%0b %h want 0 0 0", dm_req, stall, data_out_out); end
        end
        dm_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_both_high();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
